// File: rtl/cnn_layer_accel_synch_pkg.sv
// Shared types and default parameters for the CNN layer accelerator epoch barrier.
// The barrier RTL, its verification interface and its scoreboard all use these.
package cnn_layer_accel_synch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_ISSUE   = 2'd2,
      ST_ERR     = 2'd3
   } synch_barrier_state_t;

   localparam int unsigned DEF_NUM_CHANNELS = 8;
   localparam int unsigned DEF_TIMEOUT_W    = 16;
   localparam int unsigned DEF_EPOCH_W      = 16;
   localparam int unsigned DEF_AUTO_REARM   = 0;

endpackage

// File: rtl/cnn_layer_accel_synch_timer.sv
// Timeout up-counter for the epoch barrier: counts while enabled, clears on request,
// and flags the cycle in which the next increment would reach the terminal value.
module cnn_layer_accel_synch_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] term_i,
   output logic         match_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic [W-1:0] count_inc_s;

   assign count_inc_s = count_q + W'(1);
   // A terminal value of zero means the timeout is disabled, so it never matches.
   assign match_o     = (term_i != '0) && (count_inc_s == term_i);

   // Counter next-state: clear has priority over counting.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_inc_s;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/cnn_layer_accel_synch_barrier.sv
// Epoch barrier: gathers per-channel done strobes against an armed channel mask,
// offers one sync event per epoch and reports channels that miss the timeout.
module cnn_layer_accel_synch_barrier
   import cnn_layer_accel_synch_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
   parameter int unsigned TIMEOUT_W    = DEF_TIMEOUT_W,
   parameter int unsigned EPOCH_W      = DEF_EPOCH_W,
   parameter int unsigned AUTO_REARM   = DEF_AUTO_REARM
) (
   input  logic                    clk_core_i,
   input  logic                    rst_ni,
   input  logic [NUM_CHANNELS-1:0] cfg_chan_mask_i,
   input  logic [TIMEOUT_W-1:0]    cfg_timeout_i,
   input  logic                    arm_i,
   input  logic                    clear_i,
   input  logic [NUM_CHANNELS-1:0] chan_done_i,
   output logic                    sync_valid_o,
   input  logic                    sync_ready_i,
   output logic                    busy_o,
   output logic [NUM_CHANNELS-1:0] pending_mask_o,
   output logic                    err_o,
   output logic [NUM_CHANNELS-1:0] missing_mask_o,
   output logic [EPOCH_W-1:0]      epoch_cnt_o
);

   synch_barrier_state_t state_q, state_d;

   logic [NUM_CHANNELS-1:0] mask_q, mask_d;
   logic [TIMEOUT_W-1:0]    timeout_q, timeout_d;
   logic [NUM_CHANNELS-1:0] pending_q, pending_d;
   logic [NUM_CHANNELS-1:0] accum_q, accum_d;
   logic [NUM_CHANNELS-1:0] missing_q, missing_d;
   logic [EPOCH_W-1:0]      epoch_q, epoch_d;
   logic                    sync_valid_q;
   logic                    busy_q;
   logic                    err_q;

   logic [NUM_CHANNELS-1:0] done_m_s;
   logic [NUM_CHANNELS-1:0] merged_s;
   logic [NUM_CHANNELS-1:0] accum_next_s;
   logic                    timer_match_s;

   assign done_m_s     = chan_done_i & mask_q;
   assign merged_s     = pending_q | done_m_s;
   // Dones seen while the sync event waits belong to the next epoch, but only if one follows.
   assign accum_next_s = (AUTO_REARM != 0) ? (accum_q | done_m_s) : '0;

   cnn_layer_accel_synch_timer #(
      .W (TIMEOUT_W)
   ) u_timer (
      .clk_i   (clk_core_i),
      .rst_ni  (rst_ni),
      .clr_i   (state_q != ST_COLLECT),
      .en_i    (state_q == ST_COLLECT),
      .term_i  (timeout_q),
      .match_o (timer_match_s)
   );

   // Barrier next-state: completion is tested before timeout so it wins a tie.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      timeout_d = timeout_q;
      pending_d = pending_q;
      accum_d   = accum_q;
      missing_d = missing_q;
      epoch_d   = epoch_q;
      case (state_q)
         ST_IDLE: begin
            if (arm_i) begin
               mask_d    = cfg_chan_mask_i;
               timeout_d = cfg_timeout_i;
               pending_d = '0;
               accum_d   = '0;
               state_d   = (cfg_chan_mask_i == '0) ? ST_ISSUE : ST_COLLECT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            pending_d = merged_s;
            if (merged_s == mask_q) begin
               state_d = ST_ISSUE;
            end else if (timer_match_s) begin
               state_d   = ST_ERR;
               missing_d = mask_q & ~merged_s;
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_ISSUE: begin
            if (sync_ready_i) begin
               epoch_d = epoch_q + EPOCH_W'(1);
               accum_d = '0;
               if (AUTO_REARM != 0) begin
                  state_d   = ST_COLLECT;
                  pending_d = accum_next_s;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               accum_d = accum_next_s;
               state_d = ST_ISSUE;
            end
         end
         ST_ERR: begin
            if (clear_i) begin
               state_d   = ST_IDLE;
               missing_d = '0;
            end else begin
               state_d = ST_ERR;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, context and output registers; status flags are decoded from the next state.
   always_ff @(posedge clk_core_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         mask_q       <= '0;
         timeout_q    <= '0;
         pending_q    <= '0;
         accum_q      <= '0;
         missing_q    <= '0;
         epoch_q      <= '0;
         sync_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         timeout_q    <= timeout_d;
         pending_q    <= pending_d;
         accum_q      <= accum_d;
         missing_q    <= missing_d;
         epoch_q      <= epoch_d;
         sync_valid_q <= (state_d == ST_ISSUE);
         busy_q       <= (state_d != ST_IDLE);
         err_q        <= (state_d == ST_ERR);
      end
   end

   assign sync_valid_o   = sync_valid_q;
   assign busy_o         = busy_q;
   assign err_o          = err_q;
   assign pending_mask_o = pending_q;
   assign missing_mask_o = missing_q;
   assign epoch_cnt_o    = epoch_q;

endmodule

// File: tb/tb_cnn_layer_accel_synch_barrier.sv
// Bench for the epoch barrier: one single-shot instance and one auto-rearm instance
// with a narrow epoch counter, both driven by the same stimulus and tracked by a model.
module tb_cnn_layer_accel_synch_barrier;

   localparam int NC = 8;

   localparam int P_IDLE  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_OFFER = 2;
   localparam int P_FAULT = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NC-1:0] cfg_mask;
   logic [15:0]   cfg_to;
   logic          arm;
   logic          clr;
   logic [NC-1:0] done;
   logic          ready;

   logic          a_sv, a_busy, a_err;
   logic [NC-1:0] a_pend, a_miss;
   logic [15:0]   a_epoch;
   logic          b_sv, b_busy, b_err;
   logic [NC-1:0] b_pend, b_miss;
   logic [3:0]    b_epoch;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   cnn_layer_accel_synch_barrier #(
      .NUM_CHANNELS (NC), .TIMEOUT_W (16), .EPOCH_W (16), .AUTO_REARM (0)
   ) u_a (
      .clk_core_i (clk), .rst_ni (rst_n), .cfg_chan_mask_i (cfg_mask),
      .cfg_timeout_i (cfg_to), .arm_i (arm), .clear_i (clr), .chan_done_i (done),
      .sync_valid_o (a_sv), .sync_ready_i (ready), .busy_o (a_busy),
      .pending_mask_o (a_pend), .err_o (a_err), .missing_mask_o (a_miss),
      .epoch_cnt_o (a_epoch)
   );

   cnn_layer_accel_synch_barrier #(
      .NUM_CHANNELS (NC), .TIMEOUT_W (16), .EPOCH_W (4), .AUTO_REARM (1)
   ) u_b (
      .clk_core_i (clk), .rst_ni (rst_n), .cfg_chan_mask_i (cfg_mask),
      .cfg_timeout_i (cfg_to), .arm_i (arm), .clear_i (clr), .chan_done_i (done),
      .sync_valid_o (b_sv), .sync_ready_i (ready), .busy_o (b_busy),
      .pending_mask_o (b_pend), .err_o (b_err), .missing_mask_o (b_miss),
      .epoch_cnt_o (b_epoch)
   );

   // Epoch-level reference: which channels have reported, how long the epoch has run,
   // which early dones are banked for the next epoch, and how many events were taken.
   typedef struct {
      int            phase;
      logic [NC-1:0] mask;
      int            limit;
      int            elapsed;
      logic [NC-1:0] seen;
      logic [NC-1:0] early;
      logic [NC-1:0] missing;
      int            epoch;
   } model_t;

   model_t ma, mb;

   typedef struct {
      logic          arm;
      logic [NC-1:0] done;
      logic          sv;
      logic          busy;
      logic [NC-1:0] pend;
      logic [15:0]   epoch;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(logic a, logic [NC-1:0] d, logic sv, logic bz,
                               logic [NC-1:0] p, logic [15:0] e);
      vec_t v;
      v.arm = a; v.done = d; v.sv = sv; v.busy = bz; v.pend = p; v.epoch = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic mreset(inout model_t m);
      m.phase = P_IDLE; m.mask = '0; m.limit = 0; m.elapsed = 0;
      m.seen = '0; m.early = '0; m.missing = '0; m.epoch = 0;
   endtask

   task automatic mstep(inout model_t m, input bit rearm, input int ew);
      logic [NC-1:0] got;
      got = done & m.mask;
      case (m.phase)
         P_IDLE: if (arm) begin
            m.mask = cfg_mask; m.limit = int'(cfg_to); m.elapsed = 0;
            m.seen = '0; m.early = '0;
            m.phase = (cfg_mask == '0) ? P_OFFER : P_WAIT;
         end
         P_WAIT: begin
            m.seen = m.seen | got;
            if (m.seen == m.mask) m.phase = P_OFFER;
            else if (m.limit != 0 && m.elapsed + 1 == m.limit) begin
               m.phase = P_FAULT;
               m.missing = m.mask & ~m.seen;
            end else m.elapsed++;
         end
         P_OFFER: begin
            if (rearm) m.early = m.early | got;
            if (ready) begin
               m.epoch = (m.epoch + 1) % (1 << ew);
               if (rearm) begin
                  m.seen = m.early; m.early = '0; m.elapsed = 0; m.phase = P_WAIT;
               end else m.phase = P_IDLE;
            end
         end
         default: if (clr) begin
            m.phase = P_IDLE; m.missing = '0;
         end
      endcase
   endtask

   task automatic cmp_models();
      chk("A.sync_valid", 32'(a_sv), 32'(ma.phase == P_OFFER));
      chk("A.busy", 32'(a_busy), 32'(ma.phase != P_IDLE));
      chk("A.err", 32'(a_err), 32'(ma.phase == P_FAULT));
      chk("A.pending", 32'(a_pend), 32'(ma.seen));
      chk("A.missing", 32'(a_miss), 32'(ma.missing));
      chk("A.epoch", 32'(a_epoch), ma.epoch);
      chk("B.sync_valid", 32'(b_sv), 32'(mb.phase == P_OFFER));
      chk("B.busy", 32'(b_busy), 32'(mb.phase != P_IDLE));
      chk("B.err", 32'(b_err), 32'(mb.phase == P_FAULT));
      chk("B.pending", 32'(b_pend), 32'(mb.seen));
      chk("B.missing", 32'(b_miss), 32'(mb.missing));
      chk("B.epoch", 32'(b_epoch), mb.epoch);
   endtask

   // One clock: model follows the edge, outputs are compared 1 time unit later, pulses drop.
   task automatic tick();
      @(posedge clk);
      mstep(ma, 1'b0, 16);
      mstep(mb, 1'b1, 4);
      #1;
      cmp_models();
      arm = 1'b0; clr = 1'b0; done = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      arm = 1'b0; clr = 1'b0; done = '0;
      #2;
      chk("reset.A.outputs", {a_sv, a_busy, a_err, a_pend, a_miss}, 32'd0);
      chk("reset.A.epoch", 32'(a_epoch), 32'd0);
      chk("reset.B.outputs", {b_sv, b_busy, b_err, b_pend, b_miss, b_epoch}, 32'd0);
      mreset(ma);
      mreset(mb);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; cfg_mask = '0; cfg_to = '0; arm = 1'b0; clr = 1'b0;
      done = '0; ready = 1'b0;
      mreset(ma);
      mreset(mb);
      #13;
      do_reset();

      // Four-channel epoch: dones at 2, 5, 5, 9; sync event visible for one cycle.
      tbl[0]  = mk(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 16'd0);
      tbl[1]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'd0);
      tbl[2]  = mk(1'b0, 8'h01, 1'b0, 1'b1, 8'h01, 16'd0);
      tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 16'd0);
      tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 16'd0);
      tbl[5]  = mk(1'b0, 8'h06, 1'b0, 1'b1, 8'h07, 16'd0);
      tbl[6]  = mk(1'b0, 8'h30, 1'b0, 1'b1, 8'h07, 16'd0);
      tbl[7]  = mk(1'b0, 8'h01, 1'b0, 1'b1, 8'h07, 16'd0);
      tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h07, 16'd0);
      tbl[9]  = mk(1'b0, 8'h08, 1'b1, 1'b1, 8'h0F, 16'd0);
      tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h0F, 16'd1);
      tbl[11] = mk(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 16'd1);
      cfg_mask = 8'h0F; cfg_to = 16'd0; ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         arm = tbl[i].arm; done = tbl[i].done;
         tick();
         chk($sformatf("tbl[%0d].sync_valid", i), 32'(a_sv), 32'(tbl[i].sv));
         chk($sformatf("tbl[%0d].busy", i), 32'(a_busy), 32'(tbl[i].busy));
         chk($sformatf("tbl[%0d].pending", i), 32'(a_pend), 32'(tbl[i].pend));
         chk($sformatf("tbl[%0d].epoch", i), 32'(a_epoch), 32'(tbl[i].epoch));
      end

      // Timeout of 20 with only channel 0 reporting; clear returns to idle.
      do_reset();
      ready = 1'b0; cfg_mask = 8'h03; cfg_to = 16'd20;
      arm = 1'b1; tick();
      done = 8'h01; tick();
      for (int j = 2; j < 20; j++) begin
         tick();
         chk("timeout.err_early", 32'(a_err), 32'd0);
      end
      tick();
      chk("timeout.err", 32'(a_err), 32'd1);
      chk("timeout.missing", 32'(a_miss), 32'h02);
      chk("timeout.B.err", 32'(b_err), 32'd1);
      arm = 1'b1; tick();
      chk("timeout.arm_ignored", 32'(a_err), 32'd1);
      clr = 1'b1; tick();
      chk("clear.err", 32'(a_err), 32'd0);
      chk("clear.busy", 32'(a_busy), 32'd0);
      chk("clear.missing", 32'(a_miss), 32'd0);
      chk("clear.epoch", 32'(a_epoch), 32'd0);

      // Last done lands on the terminal cycle: completion wins.
      do_reset();
      ready = 1'b0; cfg_mask = 8'h03; cfg_to = 16'd5;
      arm = 1'b1; tick();
      done = 8'h01; tick();
      tick(); tick(); tick();
      done = 8'h02; tick();
      chk("tie.sync_valid", 32'(a_sv), 32'd1);
      chk("tie.err", 32'(a_err), 32'd0);
      ready = 1'b1; tick();
      ready = 1'b0;

      // Empty mask: immediate sync event held while ready is low.
      do_reset();
      ready = 1'b0; cfg_mask = 8'h00; cfg_to = 16'd0;
      arm = 1'b1; tick();
      chk("empty.sync_valid", 32'(a_sv), 32'd1);
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("empty.hold", 32'(a_sv), 32'd1);
      end
      ready = 1'b1; tick();
      chk("empty.released", 32'(a_sv), 32'd0);
      chk("empty.epoch", 32'(a_epoch), 32'd1);
      ready = 1'b0;

      // Auto-rearm: next-epoch dones banked during the offer give a fast second event.
      do_reset();
      ready = 1'b0; cfg_mask = 8'h03; cfg_to = 16'd0;
      arm = 1'b1; tick();
      done = 8'h03; tick();
      chk("rearm.first", 32'(b_sv), 32'd1);
      done = 8'h03; tick();
      ready = 1'b1; tick();
      chk("rearm.accept_sv", 32'(b_sv), 32'd0);
      chk("rearm.accept_busy", 32'(b_busy), 32'd1);
      chk("rearm.seed", 32'(b_pend), 32'h03);
      chk("rearm.epoch1", 32'(b_epoch), 32'd1);
      tick();
      chk("rearm.second", 32'(b_sv), 32'd1);
      tick();
      chk("rearm.epoch2", 32'(b_epoch), 32'd2);
      ready = 1'b0;

      // Reset in the middle of an epoch, then a fresh arm.
      do_reset();
      cfg_mask = 8'h0F; cfg_to = 16'd0;
      arm = 1'b1; tick();
      done = 8'h05; tick();
      chk("midreset.pending_before", 32'(a_pend), 32'h05);
      #3;
      do_reset();
      arm = 1'b1; tick();
      chk("midreset.pending_after", 32'(a_pend), 32'h00);
      chk("midreset.busy_after", 32'(a_busy), 32'd1);

      // Narrow epoch counter wraps after sixteen back-to-back events.
      do_reset();
      cfg_mask = 8'h00; ready = 1'b1;
      arm = 1'b1; tick();
      for (int i = 1; i <= 31; i++) begin
         tick();
         if (i == 29) chk("wrap.top", 32'(b_epoch), 32'hF);
         if (i == 31) chk("wrap.zero", 32'(b_epoch), 32'h0);
      end
      ready = 1'b0;

      // Random traffic against the model, with occasional resets.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         if ($urandom_range(0, 7) == 0) begin
            cfg_mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            cfg_to   = 16'($urandom_range(0, 25));
         end
         arm   = ($urandom_range(0, 5) == 0);
         clr   = ($urandom_range(0, 9) == 0);
         done  = 8'($urandom & $urandom);
         ready = ($urandom_range(0, 2) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
